// File: rtl/mem_ctrl.sv
// Fixed-latency word memory for the LC-3b datapath: captures one request, answers LATENCY cycles later.
// Optional MEM_CTRL_STATS_EN adds saturating completed-read/write counters.
module mem_ctrl #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata
`ifdef MEM_CTRL_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam int DEPTH = 2 ** ADDR_BITS;

   state_t                 state, state_n;
   logic [3:0]             cnt;
   logic [ADDR_BITS-1:0]   cap_idx;
   logic [15:0]            cap_wdata;
   logic [1:0]             cap_be;
   logic                   cap_rd, cap_wr;
   logic                   capture, enter_resp;

   logic [ADDR_BITS-1:0]   op_idx;
   logic [15:0]            op_wdata;
   logic [1:0]             op_be;
   logic                   op_rd, op_wr;

   logic [15:0]            mem [DEPTH];

   // Bit 0 and bits above the word index only alias; read them here so lint sees them consumed.
   logic                   unused_addr;
   assign unused_addr = ^mem_address;

   always_comb begin
      state_n    = state;
      capture    = 1'b0;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read || mem_write) begin
               capture = 1'b1;
               if (LATENCY == 1) begin
                  state_n    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_n = BUSY;
               end
            end
         end
         BUSY: begin
            if (!mem_read && !mem_write) begin
               state_n = IDLE;
            end else if (cnt == 4'd1) begin
               state_n    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // With LATENCY=1 the operation completes on the capture edge, so use the live inputs.
   always_comb begin
      if (state == IDLE) begin
         op_idx   = mem_address[ADDR_BITS:1];
         op_wdata = mem_wdata;
         op_be    = mem_byte_enable;
         op_rd    = mem_read;
         op_wr    = mem_write;
      end else begin
         op_idx   = cap_idx;
         op_wdata = cap_wdata;
         op_be    = cap_be;
         op_rd    = cap_rd;
         op_wr    = cap_wr;
      end
   end

   assign mem_resp = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cap_idx   <= '0;
         cap_wdata <= 16'h0000;
         cap_be    <= 2'b00;
         cap_rd    <= 1'b0;
         cap_wr    <= 1'b0;
         mem_rdata <= 16'h0000;
      end else begin
         state <= state_n;
         if (capture) begin
            cnt       <= 4'(LATENCY - 1);
            cap_idx   <= mem_address[ADDR_BITS:1];
            cap_wdata <= mem_wdata;
            cap_be    <= mem_byte_enable;
            cap_rd    <= mem_read;
            cap_wr    <= mem_write;
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
         end
         // Read+write loads the pre-write word since the array updates on the same edge.
         if (enter_resp && op_rd)
            mem_rdata <= mem[op_idx];
      end
   end

   // Storage survives reset; a write can only land while out of reset.
   always_ff @(posedge clk) begin
      if (rst_n && enter_resp && op_wr) begin
         if (op_be[1]) mem[op_idx][15:8] <= op_wdata[15:8];
         if (op_be[0]) mem[op_idx][7:0]  <= op_wdata[7:0];
      end
   end

`ifdef MEM_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count <= 16'h0000;
         wr_count <= 16'h0000;
      end else if (enter_resp) begin
         if (op_wr) begin
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
         end else if (op_rd) begin
            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: one instance at LATENCY=3, one at LATENCY=1, sharing clock and reset.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r_rd   [2];
   logic        r_wr   [2];
   logic [1:0]  r_be   [2];
   logic [15:0] r_addr [2];
   logic [15:0] r_wd   [2];
   logic        resp   [2];
   logic [15:0] rdata  [2];
`ifdef MEM_CTRL_STATS_EN
   logic [15:0] rd_cnt [2];
   logic [15:0] wr_cnt [2];
`endif

   int          lat [2] = '{3, 1};
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] mdl [2][256];
   logic [15:0] exp_rd [2];
   logic [15:0] sb_q [$];

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_BITS(8), .LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .mem_read(r_rd[0]), .mem_write(r_wr[0]),
      .mem_byte_enable(r_be[0]), .mem_address(r_addr[0]), .mem_wdata(r_wd[0]),
      .mem_resp(resp[0]), .mem_rdata(rdata[0])
`ifdef MEM_CTRL_STATS_EN
      , .rd_count(rd_cnt[0]), .wr_count(wr_cnt[0])
`endif
   );

   mem_ctrl #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .mem_read(r_rd[1]), .mem_write(r_wr[1]),
      .mem_byte_enable(r_be[1]), .mem_address(r_addr[1]), .mem_wdata(r_wd[1]),
      .mem_resp(resp[1]), .mem_rdata(rdata[1])
`ifdef MEM_CTRL_STATS_EN
      , .rd_count(rd_cnt[1]), .wr_count(wr_cnt[1])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         r_rd[d] = 1'b0; r_wr[d] = 1'b0; r_be[d] = 2'b00;
         r_addr[d] = 16'h0; r_wd[d] = 16'h0;
      end
   endtask

   // Full transaction: expected rdata is pushed at drive time, popped when mem_resp appears.
   task automatic txn(input int d, input bit rd, input bit wr, input logic [1:0] be,
                      input logic [15:0] addr, input logic [15:0] data, input string tag);
      logic [7:0] idx;
      bit got;
      @(negedge clk);
      r_rd[d] = rd; r_wr[d] = wr; r_be[d] = be; r_addr[d] = addr; r_wd[d] = data;
      idx = addr[8:1];
      if (rd) exp_rd[d] = mdl[d][idx];
      if (wr) begin
         if (be[1]) mdl[d][idx][15:8] = data[15:8];
         if (be[0]) mdl[d][idx][7:0]  = data[7:0];
      end
      sb_q.push_back(exp_rd[d]);
      got = 1'b0;
      for (int k = 1; k <= lat[d] + 3 && !got; k++) begin
         @(posedge clk); #1;
         if (resp[d]) begin
            got = 1'b1;
            r_rd[d] = 1'b0; r_wr[d] = 1'b0;
            chk({tag, "_lat"}, k, lat[d]);
            chk({tag, "_rdata"}, rdata[d], sb_q.pop_front());
         end
      end
      if (!got) begin
         chk({tag, "_timeout"}, 0, 1);
         void'(sb_q.pop_front());
         r_rd[d] = 1'b0; r_wr[d] = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, "_pulse1"}, resp[d], 1'b0);
   endtask

   initial begin
      bit seen;
      idle_all();
      exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
      #12;
      chk("rst_resp", resp[0], 1'b0);
      chk("rst_rdata", rdata[0], 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // LATENCY=3: full write then read back
      txn(0, 0, 1, 2'b11, 16'h0010, 16'hBEEF, "wr_beef");
      txn(0, 1, 0, 2'b00, 16'h0010, 16'h0000, "rd_beef");
      // byte masks
      txn(0, 0, 1, 2'b11, 16'h0020, 16'h1234, "wr_1234");
      txn(0, 0, 1, 2'b10, 16'h0020, 16'hAB00, "wr_hi");
      txn(0, 1, 0, 2'b00, 16'h0020, 16'h0000, "rd_ab34");
      txn(0, 0, 1, 2'b00, 16'h0020, 16'hFFFF, "wr_none");
      txn(0, 1, 0, 2'b00, 16'h0020, 16'h0000, "rd_unch");
      txn(0, 0, 1, 2'b01, 16'h0021, 16'h00CD, "wr_lo_odd");
      txn(0, 1, 0, 2'b00, 16'h0020, 16'h0000, "rd_abcd");
      // read+write together: write wins, rdata gets the old word
      txn(0, 1, 1, 2'b11, 16'h0010, 16'h1111, "rw_both");
      txn(0, 1, 0, 2'b00, 16'h0010, 16'h0000, "rd_1111");

      // abort: drop a write one cycle into BUSY
      txn(0, 0, 1, 2'b11, 16'h0040, 16'h0F0F, "wr_0f0f");
      @(negedge clk);
      r_wr[0] = 1'b1; r_be[0] = 2'b11; r_addr[0] = 16'h0040; r_wd[0] = 16'hDEAD;
      @(negedge clk); @(negedge clk);
      r_wr[0] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (resp[0]) seen = 1'b1;
      end
      chk("abort_resp", seen, 1'b0);
      txn(0, 1, 0, 2'b00, 16'h0040, 16'h0000, "rd_after_abort");

      // LATENCY=1: preload then back-to-back held reads
      txn(1, 0, 1, 2'b11, 16'h0000, 16'h0A0A, "l1_wr0");
      txn(1, 0, 1, 2'b11, 16'h0002, 16'h0B0B, "l1_wr2");
      @(negedge clk);
      r_rd[1] = 1'b1; r_addr[1] = 16'h0000;
      @(posedge clk); #1;
      chk("b2b_resp_c1", resp[1], 1'b1);
      chk("b2b_rdata_c1", rdata[1], 16'h0A0A);
      r_addr[1] = 16'h0002;
      @(posedge clk); #1;
      chk("b2b_resp_c2", resp[1], 1'b0);
      @(posedge clk); #1;
      chk("b2b_resp_c3", resp[1], 1'b1);
      chk("b2b_rdata_c3", rdata[1], 16'h0B0B);
      r_rd[1] = 1'b0;
      @(posedge clk); #1;
      chk("b2b_resp_c4", resp[1], 1'b0);

      // reset in the middle of a write
      @(negedge clk);
      r_wr[0] = 1'b1; r_be[0] = 2'b11; r_addr[0] = 16'h0040; r_wd[0] = 16'hBAD0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_resp", resp[0], 1'b0);
      chk("midrst_rdata", rdata[0], 16'h0000);
      r_wr[0] = 1'b0;
      exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
      @(negedge clk);
      rst_n = 1'b1;

      // aliasing: 0x0201 maps onto word 0
      txn(0, 0, 1, 2'b11, 16'h0201, 16'h5A5A, "wr_alias");
      txn(0, 1, 0, 2'b00, 16'h0000, 16'h0000, "rd_alias");
`ifdef MEM_CTRL_STATS_EN
      chk("rd_count", rd_cnt[0], 16'd1);
      chk("wr_count", wr_cnt[0], 16'd1);
`endif
      txn(0, 1, 0, 2'b00, 16'h0040, 16'h0000, "rd_no_partial");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
